// File: rtl/ex_div_pkg.sv
// Shared state encoding and handshake level constants for the EX-stage divider.
package ex_div_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;
   localparam logic STALL_STOP           = 1'b1;
   localparam logic STALL_NOSTOP         = 1'b0;

endpackage

// File: rtl/ex_div_if.sv
// EX <-> divider request/result bundle; master is the EX issue logic, slave is the divider.
interface ex_div_if #(
   parameter int DATA_W = ex_div_pkg::DIV_DATA_W
);
   import ex_div_pkg::*;

   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;
   logic                  stallreq_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, stallreq_o
   );

endinterface

// File: rtl/ex_div.sv
// Radix-2 shift-subtract DIV/DIVU: {rem,quot} ready DATA_W+1 edges after accept (2 for divide-by-zero).
// Stall request stays high while start_i is held and no result is ready; result held until start_i drops.
module ex_div
   import ex_div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic    clk,
   input  logic    rst,
   ex_div_if.slave bus
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   div_state_t            r_state, w_state;
   logic [CNT_W-1:0]      r_cnt, w_cnt;
   logic [DATA_W-1:0]     r_dividend, w_dividend;
   logic [DATA_W-1:0]     r_divisor, w_divisor;
   logic [DATA_W-1:0]     r_rem, w_rem;
   logic [DATA_W-1:0]     r_quot, w_quot;
   logic                  r_neg_q, w_neg_q;
   logic                  r_neg_r, w_neg_r;
   logic                  r_ready, w_ready;
   logic [2*DATA_W-1:0]   r_result, w_result;

   logic [DATA_W:0]       w_shift;
   logic [DATA_W:0]       w_diff;
   logic                  w_qbit;
   logic [DATA_W-1:0]     w_rem_step;
   logic [DATA_W-1:0]     w_quot_step;
   logic                  w_sign1;
   logic                  w_sign2;

   function automatic logic [DATA_W-1:0] fix_sign(input logic neg, input logic [DATA_W-1:0] v);
      return neg ? -v : v;
   endfunction

   // 33-bit trial subtract: the shifted partial remainder may exceed DATA_W bits before subtraction.
   assign w_shift     = {r_rem, r_dividend[DATA_W-1]};
   assign w_diff      = w_shift - {1'b0, r_divisor};
   assign w_qbit      = ~w_diff[DATA_W];
   assign w_rem_step  = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
   assign w_quot_step = {r_quot[DATA_W-2:0], w_qbit};
   assign w_sign1     = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
   assign w_sign2     = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_dividend = r_dividend;
      w_divisor  = r_divisor;
      w_rem      = r_rem;
      w_quot     = r_quot;
      w_neg_q    = r_neg_q;
      w_neg_r    = r_neg_r;
      w_ready    = r_ready;
      w_result   = r_result;
      case (r_state)
         DIV_FREE: begin
            w_ready  = DIV_RESULT_NOT_READY;
            w_result = '0;
            if (bus.start_i == DIV_START && !bus.annul_i) begin
               if (bus.opdata2_i == '0) begin
                  w_state = DIV_BYZERO;
               end else begin
                  w_state    = DIV_ON;
                  w_dividend = fix_sign(w_sign1, bus.opdata1_i);
                  w_divisor  = fix_sign(w_sign2, bus.opdata2_i);
                  w_neg_q    = w_sign1 ^ w_sign2;
                  w_neg_r    = w_sign1;
                  w_cnt      = '0;
                  w_rem      = '0;
                  w_quot     = '0;
               end
            end
         end
         DIV_BYZERO: begin
            w_result = '0;
            if (bus.annul_i) begin
               w_state = DIV_FREE;
               w_ready = DIV_RESULT_NOT_READY;
            end else begin
               w_state = DIV_END;
               w_ready = DIV_RESULT_READY;
            end
         end
         DIV_ON: begin
            if (bus.annul_i) begin
               w_state = DIV_FREE;
            end else begin
               w_dividend = {r_dividend[DATA_W-2:0], 1'b0};
               w_rem      = w_rem_step;
               w_quot     = w_quot_step;
               w_cnt      = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  w_state  = DIV_END;
                  w_ready  = DIV_RESULT_READY;
                  w_result = {fix_sign(r_neg_r, w_rem_step), fix_sign(r_neg_q, w_quot_step)};
               end
            end
         end
         DIV_END: begin
            if (bus.annul_i || bus.start_i == DIV_STOP) begin
               w_state  = DIV_FREE;
               w_ready  = DIV_RESULT_NOT_READY;
               w_result = '0;
            end
         end
         default: begin
            w_state  = DIV_FREE;
            w_ready  = DIV_RESULT_NOT_READY;
            w_result = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= DIV_FREE;
         r_cnt      <= '0;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_rem      <= '0;
         r_quot     <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_ready    <= DIV_RESULT_NOT_READY;
         r_result   <= '0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_dividend <= w_dividend;
         r_divisor  <= w_divisor;
         r_rem      <= w_rem;
         r_quot     <= w_quot;
         r_neg_q    <= w_neg_q;
         r_neg_r    <= w_neg_r;
         r_ready    <= w_ready;
         r_result   <= w_result;
      end
   end

   assign bus.result_o   = r_result;
   assign bus.ready_o    = r_ready;
   assign bus.stallreq_o = (bus.start_i == DIV_START && r_ready == DIV_RESULT_NOT_READY) ?
                           STALL_STOP : STALL_NOSTOP;

endmodule

// File: tb/tb_ex_div.sv
// Directed-vector bench for ex_div: latency, stall window, signed fix-up, divide-by-zero, annul and reset.
module tb_ex_div;
   import ex_div_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_total = 0;
   int   n_bad   = 0;

   ex_div_if dif ();

   ex_div u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one division, measure edges to ready and stall cycles, optionally hold, then consume.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_res, input int exp_lat, input int hold, input bit scramble);
      int lat;
      int stall_cyc;
      lat       = 0;
      stall_cyc = 0;
      dif.signed_div_i = sgn;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      dif.annul_i      = 1'b0;
      dif.start_i      = 1'b1;
      #1;
      while (dif.ready_o !== 1'b1 && lat < 100) begin
         if (dif.stallreq_o === 1'b1) stall_cyc++;
         tick();
         lat++;
         if (scramble && lat == 1) begin
            dif.opdata1_i    = ~a;
            dif.opdata2_i    = 32'h3;
            dif.signed_div_i = ~sgn;
         end
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_stallcyc"}, 64'(stall_cyc), 64'(exp_lat));
      chk({tag, "_stall_rdy"}, 64'(dif.stallreq_o), 64'd0);
      chk({tag, "_res"}, dif.result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_rdy"}, 64'(dif.ready_o), 64'd1);
         chk({tag, "_hold_res"}, dif.result_o, exp_res);
      end
      dif.start_i = 1'b0;
      tick();
      chk({tag, "_free_rdy"}, 64'(dif.ready_o), 64'd0);
      chk({tag, "_free_res"}, dif.result_o, 64'd0);
   endtask

   initial begin
      int rdy_seen;
      rst              = 1'b0;
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = '0;
      dif.opdata2_i    = '0;
      dif.start_i      = 1'b0;
      dif.annul_i      = 1'b0;
      #12;
      chk("rst_rdy", 64'(dif.ready_o), 64'd0);
      chk("rst_res", dif.result_o, 64'd0);
      chk("rst_stall0", 64'(dif.stallreq_o), 64'd0);
      dif.start_i = 1'b1;
      #1;
      chk("rst_stall1", 64'(dif.stallreq_o), 64'd1);
      dif.start_i = 1'b0;
      rst         = 1'b1;
      tick();

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1, 1'b1);
      run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 1, 1'b0);
      run_div("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1, 1'b0);
      run_div("div_zero", 1'b0, 32'h00001234, 32'h0, 64'h0, 2, 3, 1'b0);

      // annul held in FREE must block acceptance
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd20;
      dif.opdata2_i    = 32'd4;
      dif.start_i      = 1'b1;
      dif.annul_i      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("blk_rdy", 64'(dif.ready_o), 64'd0);
         chk("blk_stall", 64'(dif.stallreq_o), 64'd1);
      end
      run_div("after_blk", 1'b0, 32'd20, 32'd4, 64'h00000000_00000005, 33, 1, 1'b0);

      // annul after 10 cycles in ON
      dif.opdata1_i = 32'd1000;
      dif.opdata2_i = 32'd3;
      dif.start_i   = 1'b1;
      tick();
      rdy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dif.ready_o === 1'b1) rdy_seen++;
      end
      dif.annul_i = 1'b1;
      dif.start_i = 1'b0;
      #1;
      chk("an_stall", 64'(dif.stallreq_o), 64'd0);
      tick();
      if (dif.ready_o === 1'b1) rdy_seen++;
      chk("an_rdy_never", 64'(rdy_seen), 64'd0);
      chk("an_res", dif.result_o, 64'd0);
      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 1, 1'b0);

      run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 1, 1'b0);
      run_div("divu_max", 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33, 1, 1'b0);

      // asynchronous reset in the middle of ON
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd12345;
      dif.opdata2_i    = 32'd6;
      dif.start_i      = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      #3;
      rst = 1'b0;
      #1;
      chk("rstm_rdy", 64'(dif.ready_o), 64'd0);
      chk("rstm_res", dif.result_o, 64'd0);
      chk("rstm_stall", 64'(dif.stallreq_o), 64'd1);
      tick();
      dif.start_i = 1'b0;
      rst         = 1'b1;
      tick();

      // asynchronous reset while a result is held in END
      dif.start_i = 1'b1;
      rdy_seen    = 0;
      while (dif.ready_o !== 1'b1 && rdy_seen < 100) begin
         tick();
         rdy_seen++;
      end
      chk("rste_lat", 64'(rdy_seen), 64'd33);
      chk("rste_res_pre", dif.result_o, 64'h00000003_00000809);
      #3;
      rst = 1'b0;
      #1;
      chk("rste_rdy", 64'(dif.ready_o), 64'd0);
      chk("rste_res", dif.result_o, 64'd0);
      tick();
      dif.start_i = 1'b0;
      rst         = 1'b1;
      tick();
      run_div("divu_50_5", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle 32-bit signed/unsigned divider in the execute stage. It serves DIV/DIVU issued by the EX logic.
- It is the source side of the pipeline stall protocol. While a division is pending it raises a stall request to ctrl, which holds the stall vector so the ID/EX register freezes or bubbles.
- It returns {remainder, quotient} for the HI/LO write.
- Algorithm: radix-2 shift-subtract, one quotient bit per cycle.

Parameters:
- DATA_W, 32, operand width. The result is 2*DATA_W. The iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  EX requests a division; held high until the result is consumed
- annul_i  in  1  cancel the in-flight division (branch-delay flush / exception)
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1
- ready_o  out  1  result valid
- stallreq_o  out  1  stall request to ctrl; combinational, equals start_i & ~ready_o

Behaviour:
- Reset (rst=0, asynchronous): state=FREE, result_o=0, ready_o=0, cnt=0, internal dividend/divisor/sign registers cleared. stallreq_o follows its equation.
- States: FREE, BYZERO, ON, END. All transitions occur on the clk rising edge.
- FREE:
  - start_i=1, annul_i=0, opdata2_i=0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. Latch |op1| and |op2| (absolute value when signed_div_i=1, raw otherwise). Latch the negate-quotient flag (sign1 XOR sign2) and the negate-remainder flag (sign1). Set cnt=0.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next state END with result 0.
- ON:
  - annul_i=1 -> FREE; ready_o stays 0 and nothing is written.
  - Otherwise perform one iteration per cycle. The partial remainder is kept at 33 bits. Shift in the next dividend bit, trial-subtract the divisor, set the quotient bit to 1 when the subtraction is non-negative.
  - cnt increments each iteration. After the iteration with cnt=DATA_W-1 -> END.
  - On the END transition, apply sign fix-up: negate the quotient if the negate-quotient flag is set; negate the remainder if the negate-remainder flag is set. Register result_o and set ready_o=1.
- END:
  - ready_o=1 and result_o are held while start_i=1.
  - start_i=0 -> FREE, ready_o=0, result_o=0.
- Latency: count the accepting edge as edge 1.
  - Non-zero divisor: ready_o rises after edge DATA_W+1 (33). stallreq_o is high for 33 cycles.
  - Zero divisor: ready_o rises after edge 2.
- Stall handshake: in END, stallreq_o drops, the pipeline advances one cycle, EX writes HI/LO and deasserts start_i.
- annul_i in FREE, BYZERO or END: return to FREE and clear ready_o. In FREE, annul_i blocks acceptance.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient wraps to 0x80000000, remainder 0. This is not an exception.
- Operand changes while in ON/END are ignored; the operands are latched at acceptance.
- Reset mid-operation aborts immediately to the reset state.

Decomposition:
- Add to defines.v:
  - state encodings DivFree, DivByZero, DivOn, DivEnd (2 bits)
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - the existing Stop / NoStop for stallreq_o
- No sub-module. The iteration datapath (33-bit subtract plus shift) stays inline. Sign fix-up is a local function.

Test Plan:
- DIVU 100/7: ready after 33 edges, result_o=0x00000002_0000000E; stallreq_o high exactly 33 cycles, then low.
- DIV -7/2 (0xFFFFFFF9/0x00000002): result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3). Repeat with 7/-2: result_o=0x00000001_FFFFFFFD.
- Divide by zero (0x1234/0): ready_o after 2 edges, result_o=0; hold start_i 3 more cycles, result stays 0 and ready stays 1; drop start_i, next edge FREE.
- Annul at cycle 10 of ON: next edge FREE, ready_o never rises, stallreq_o=0 once start_i=0. An immediate new DIVU 9/3 then yields 0x00000000_00000003.
- Signed 0x80000000/0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- rst pulsed low mid-division (asynchronous, between edges): ready_o=0 and result_o=0 immediately. After release, a new 50/5 completes with 0x00000000_0000000A.
